// File: rtl/ddr_pkg.sv
// Shared DDR4 command-sequencer types: host request ops, JEDEC command codes,
// the registered command/address pin bundle and the per-command pin encoder.
package ddr_pkg;

   // Host request operation stored in each FIFO entry
   typedef enum logic [1:0] {
      RD_R  = 2'd0,
      WR_R  = 2'd1,
      RDA_R = 2'd2,
      WRA_R = 2'd3
   } rw_req_t;

   // Command presented on the pins, also reported on cmd_issued
   typedef enum logic [3:0] {
      DES  = 4'd0,
      NOP  = 4'd1,
      ACT  = 4'd2,
      RD   = 4'd3,
      RDA  = 4'd4,
      WR   = 4'd5,
      WRA  = 4'd6,
      PRE  = 4'd7,
      PREA = 4'd8,
      REF  = 4'd9,
      MRS  = 4'd10,
      ZQCL = 4'd11
   } ddr_cmd_t;

   // Command/address pins shared by all ranks; chip selects live in the top
   // because their width follows the RANKS parameter.
   typedef struct packed {
      logic       act_n;
      logic       ras_n;
      logic       cas_n;
      logic       we_n;
      logic       a17;
      logic       a13;
      logic       a12;
      logic       a11;
      logic       a10;
      logic [1:0] bg;
      logic [1:0] ba;
      logic [9:0] a9_a0;
   } ddr_pins_t;

   // RAS_n/CAS_n/WE_n patterns, packed as {RAS, CAS, WE}
   localparam logic [2:0] RCW_DES  = 3'b111;
   localparam logic [2:0] RCW_RD   = 3'b101;
   localparam logic [2:0] RCW_WR   = 3'b100;
   localparam logic [2:0] RCW_PRE  = 3'b010;
   localparam logic [2:0] RCW_PREA = 3'b010;
   localparam logic [2:0] RCW_REF  = 3'b001;
   localparam logic [2:0] RCW_ZQCL = 3'b110;
   localparam logic [2:0] RCW_MRS  = 3'b000;

   // Idle bus: every pin high, which is also the base for every command so
   // that address pins a command does not use are driven to 1.
   localparam ddr_pins_t PINS_DES = '1;

   // Translate one command plus its operands into pin levels.
   function automatic ddr_pins_t encodePins(
      input ddr_cmd_t    cmd,
      input logic [1:0]  bg,
      input logic [1:0]  ba,
      input logic [17:0] row,
      input logic [9:0]  col,
      input logic [21:0] mrsData
   );
      ddr_pins_t pins;
      pins = PINS_DES;
      case (cmd)
         ACT: begin
            pins.act_n = 1'b0;
            {pins.a17, pins.ras_n, pins.cas_n, pins.we_n,
             pins.a13, pins.a12, pins.a11, pins.a10, pins.a9_a0} = row;
            pins.bg = bg;
            pins.ba = ba;
         end
         PRE: begin
            {pins.ras_n, pins.cas_n, pins.we_n} = RCW_PRE;
            pins.a10 = 1'b0;
            pins.bg  = bg;
            pins.ba  = ba;
         end
         RD, RDA, WR, WRA: begin
            {pins.ras_n, pins.cas_n, pins.we_n} =
               ((cmd == RD) || (cmd == RDA)) ? RCW_RD : RCW_WR;
            pins.a10   = (cmd == RDA) || (cmd == WRA);
            pins.a12   = 1'b1;
            pins.a9_a0 = col;
            pins.bg    = bg;
            pins.ba    = ba;
         end
         PREA: begin
            {pins.ras_n, pins.cas_n, pins.we_n} = RCW_PREA;
            pins.a10 = 1'b1;
         end
         REF: begin
            {pins.ras_n, pins.cas_n, pins.we_n} = RCW_REF;
         end
         ZQCL: begin
            {pins.ras_n, pins.cas_n, pins.we_n} = RCW_ZQCL;
            pins.a10 = 1'b1;
         end
         MRS: begin
            {pins.ras_n, pins.cas_n, pins.we_n} = RCW_MRS;
            {pins.bg, pins.ba} = mrsData[21:18];
            pins.a17 = mrsData[17];
            {pins.a13, pins.a12, pins.a11, pins.a10, pins.a9_a0} = mrsData[13:0];
         end
         default: begin
            pins = PINS_DES;
         end
      endcase
      return pins;
   endfunction

endpackage

// File: rtl/ddr_req_fifo.sv
// Request FIFO: power-of-two depth, wrapping pointers, separate occupancy
// counter, combinational head read, synchronous active-high reset.
module ddr_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rdPtr];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   // Storage write; contents need no reset since the counter gates reads
   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointers wrap naturally modulo DEPTH; occupancy tracked separately
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// DDR4 command sequencer: queues host requests, arbitrates the FSM command
// strobes, and drives registered command/address pins and chip selects.
module ddr_cmd_sequencer
   import ddr_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int RANKS  = 1,
   parameter int ROW_W  = 18,
   parameter int COL_W  = 10,
   localparam int RANK_W = (RANKS > 1) ? $clog2(RANKS) : 1,
   localparam int CNT_W  = $clog2(DEPTH+1)
) (
   input  logic              CK_t,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [RANK_W-1:0] req_rank,
   input  logic [1:0]        req_bg,
   input  logic [1:0]        req_ba,
   input  logic [ROW_W-1:0]  req_row,
   input  logic [COL_W-1:0]  req_col,
   input  logic              act_rdy,
   input  logic              cas_rdy,
   input  logic              pre_rdy,
   input  logic              prea_rdy,
   input  logic              ref_rdy,
   input  logic              mrs_rdy,
   input  logic              zqcl_rdy,
   input  logic              des_rdy,
   input  logic [21:0]       mrs_data,
   output logic [RANKS-1:0]  cs_n,
   output logic              act_n,
   output logic              RAS_n_A16,
   output logic              CAS_n_A15,
   output logic              WE_n_A14,
   output logic              A17,
   output logic              A13,
   output logic              A12_BC_n,
   output logic              A11,
   output logic              A10_AP,
   output logic [1:0]        bg_addr,
   output logic [1:0]        ba_addr,
   output logic [9:0]        A9_A0,
   output logic [3:0]        cmd_issued,
   output logic [CNT_W-1:0]  q_count,
   output logic              cmd_err
);

   localparam int ENTRY_W = 2 + RANK_W + 4 + ROW_W + COL_W;

   logic [ENTRY_W-1:0] w_pushData;
   logic [ENTRY_W-1:0] w_head;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;

   logic [1:0]         w_headOp;
   logic [RANK_W-1:0]  w_headRank;
   logic [1:0]         w_headBg;
   logic [1:0]         w_headBa;
   logic [ROW_W-1:0]   w_headRow;
   logic [COL_W-1:0]   w_headCol;
   logic [17:0]        w_row18;
   logic [9:0]         w_col10;

   logic [7:0]         w_strobes;
   logic               w_multi;
   logic               w_underflow;
   logic               w_rankCmd;
   logic               w_bcastCmd;
   ddr_cmd_t           w_cmd;
   ddr_pins_t          w_pins;
   logic [RANKS-1:0]   w_csN;

   ddr_pins_t          r_pins;
   logic [RANKS-1:0]   r_csN;
   ddr_cmd_t           r_cmd;
   logic               r_err;

   assign w_push     = req_valid && !w_full;
   assign req_ready  = !w_full;
   assign w_pushData = {req_op, req_rank, req_bg, req_ba, req_row, req_col};
   assign {w_headOp, w_headRank, w_headBg, w_headBa, w_headRow, w_headCol} = w_head;

   ddr_req_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_reqFifo (
      .i_clock (CK_t),
      .i_reset (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_pushData),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (q_count)
   );

   // Zero-extend the queued row/column onto the full A17..A0 / A9..A0 pins
   always_comb begin
      w_row18 = '0;
      w_col10 = '0;
      w_row18[ROW_W-1:0] = w_headRow;
      w_col10[COL_W-1:0] = w_headCol;
   end

   assign w_strobes = {des_rdy, ref_rdy, prea_rdy, pre_rdy,
                       mrs_rdy, zqcl_rdy, act_rdy, cas_rdy};
   assign w_multi   = ($countones(w_strobes) > 1);

   // Fixed-priority arbitration; queue-based commands fall back to DES when empty
   always_comb begin
      w_cmd       = DES;
      w_pop       = 1'b0;
      w_underflow = 1'b0;
      w_rankCmd   = 1'b0;
      w_bcastCmd  = 1'b0;
      if (des_rdy) begin
         w_cmd = DES;
      end else if (ref_rdy) begin
         w_cmd      = REF;
         w_bcastCmd = 1'b1;
      end else if (prea_rdy) begin
         w_cmd      = PREA;
         w_bcastCmd = 1'b1;
      end else if (pre_rdy) begin
         if (w_empty) begin
            w_underflow = 1'b1;
         end else begin
            w_cmd     = PRE;
            w_rankCmd = 1'b1;
         end
      end else if (mrs_rdy) begin
         w_cmd      = MRS;
         w_bcastCmd = 1'b1;
      end else if (zqcl_rdy) begin
         w_cmd      = ZQCL;
         w_bcastCmd = 1'b1;
      end else if (act_rdy) begin
         if (w_empty) begin
            w_underflow = 1'b1;
         end else begin
            w_cmd     = ACT;
            w_rankCmd = 1'b1;
         end
      end else if (cas_rdy) begin
         if (w_empty) begin
            w_underflow = 1'b1;
         end else begin
            w_rankCmd = 1'b1;
            w_pop     = 1'b1;
            case (rw_req_t'(w_headOp))
               RD_R:    w_cmd = RD;
               WR_R:    w_cmd = WR;
               RDA_R:   w_cmd = RDA;
               WRA_R:   w_cmd = WRA;
               default: w_cmd = RD;
            endcase
         end
      end
   end

   // Chip selects: broadcast commands hit every rank, queue commands only the head's rank
   always_comb begin
      w_csN = '1;
      for (int r = 0; r < RANKS; r++) begin
         if (w_bcastCmd || (w_rankCmd && (w_headRank == RANK_W'(r)))) begin
            w_csN[r] = 1'b0;
         end
      end
   end

   assign w_pins = encodePins(w_cmd, w_headBg, w_headBa, w_row18, w_col10, mrs_data);

   // Register every pin, the command code and the error pulse for one-cycle latency
   always_ff @(posedge CK_t) begin
      if (reset) begin
         r_pins <= PINS_DES;
         r_csN  <= '1;
         r_cmd  <= DES;
         r_err  <= 1'b0;
      end else begin
         r_pins <= w_pins;
         r_csN  <= w_csN;
         r_cmd  <= w_cmd;
         r_err  <= w_multi || w_underflow;
      end
   end

   assign cs_n       = r_csN;
   assign act_n      = r_pins.act_n;
   assign RAS_n_A16  = r_pins.ras_n;
   assign CAS_n_A15  = r_pins.cas_n;
   assign WE_n_A14   = r_pins.we_n;
   assign A17        = r_pins.a17;
   assign A13        = r_pins.a13;
   assign A12_BC_n   = r_pins.a12;
   assign A11        = r_pins.a11;
   assign A10_AP     = r_pins.a10;
   assign bg_addr    = r_pins.bg;
   assign ba_addr    = r_pins.ba;
   assign A9_A0      = r_pins.a9_a0;
   assign cmd_issued = r_cmd;
   assign cmd_err    = r_err;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer (DEPTH=8, RANKS=2): a table of
// single-cycle vectors plus hand-written fill/wrap and reset sequences.
module tb_ddr_cmd_sequencer;
   import ddr_pkg::*;

   localparam logic [7:0] S_NONE = 8'h00;
   localparam logic [7:0] S_CAS  = 8'h01;
   localparam logic [7:0] S_ACT  = 8'h02;
   localparam logic [7:0] S_ZQ   = 8'h04;
   localparam logic [7:0] S_MRS  = 8'h08;
   localparam logic [7:0] S_PRE  = 8'h10;
   localparam logic [7:0] S_PREA = 8'h20;
   localparam logic [7:0] S_REF  = 8'h40;
   localparam logic [7:0] S_DES  = 8'h80;

   typedef struct {
      logic        push;
      logic [1:0]  op;
      logic        rank;
      logic [1:0]  bg;
      logic [1:0]  ba;
      logic [17:0] row;
      logic [9:0]  col;
      logic [7:0]  stb;
      logic [21:0] mrs;
      logic [3:0]  eCmd;
      logic [1:0]  eCs;
      logic        eActN;
      logic [2:0]  eRcw;
      logic        eA17;
      logic        eA10;
      logic [9:0]  eA9;
      logic [1:0]  eBg;
      logic [1:0]  eBa;
      logic        eErr;
      logic [3:0]  eQ;
   } vec_t;

   logic        CK_t;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [0:0]  req_rank;
   logic [1:0]  req_bg;
   logic [1:0]  req_ba;
   logic [17:0] req_row;
   logic [9:0]  req_col;
   logic        act_rdy, cas_rdy, pre_rdy, prea_rdy, ref_rdy, mrs_rdy, zqcl_rdy, des_rdy;
   logic [21:0] mrs_data;
   logic [1:0]  cs_n;
   logic        act_n, RAS_n_A16, CAS_n_A15, WE_n_A14, A17, A13, A12_BC_n, A11, A10_AP;
   logic [1:0]  bg_addr;
   logic [1:0]  ba_addr;
   logic [9:0]  A9_A0;
   logic [3:0]  cmd_issued;
   logic [3:0]  q_count;
   logic        cmd_err;

   int checks   = 0;
   int failures = 0;

   ddr_cmd_sequencer #(
      .DEPTH (8),
      .RANKS (2),
      .ROW_W (18),
      .COL_W (10)
   ) dut (
      .CK_t       (CK_t),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_rank   (req_rank),
      .req_bg     (req_bg),
      .req_ba     (req_ba),
      .req_row    (req_row),
      .req_col    (req_col),
      .act_rdy    (act_rdy),
      .cas_rdy    (cas_rdy),
      .pre_rdy    (pre_rdy),
      .prea_rdy   (prea_rdy),
      .ref_rdy    (ref_rdy),
      .mrs_rdy    (mrs_rdy),
      .zqcl_rdy   (zqcl_rdy),
      .des_rdy    (des_rdy),
      .mrs_data   (mrs_data),
      .cs_n       (cs_n),
      .act_n      (act_n),
      .RAS_n_A16  (RAS_n_A16),
      .CAS_n_A15  (CAS_n_A15),
      .WE_n_A14   (WE_n_A14),
      .A17        (A17),
      .A13        (A13),
      .A12_BC_n   (A12_BC_n),
      .A11        (A11),
      .A10_AP     (A10_AP),
      .bg_addr    (bg_addr),
      .ba_addr    (ba_addr),
      .A9_A0      (A9_A0),
      .cmd_issued (cmd_issued),
      .q_count    (q_count),
      .cmd_err    (cmd_err)
   );

   // Free-running clock, 10 time units per cycle
   initial CK_t = 1'b0;
   always #5 CK_t = ~CK_t;

   // Hard time limit so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs (inputs change at the falling edge), then
   // return at the next falling edge with the registered results visible.
   task automatic applyStimulus(input vec_t v);
      req_valid = v.push;
      req_op    = v.op;
      req_rank  = v.rank;
      req_bg    = v.bg;
      req_ba    = v.ba;
      req_row   = v.row;
      req_col   = v.col;
      {des_rdy, ref_rdy, prea_rdy, pre_rdy, mrs_rdy, zqcl_rdy, act_rdy, cas_rdy} = v.stb;
      mrs_data  = v.mrs;
      @(posedge CK_t);
      @(negedge CK_t);
   endtask

   task automatic checkVector(input int i, input vec_t v);
      checkOutput($sformatf("v%0d_cmd", i), 32'(cmd_issued), 32'(v.eCmd));
      checkOutput($sformatf("v%0d_cs_n", i), 32'(cs_n), 32'(v.eCs));
      checkOutput($sformatf("v%0d_act_n", i), 32'(act_n), 32'(v.eActN));
      checkOutput($sformatf("v%0d_rcw", i), 32'({RAS_n_A16, CAS_n_A15, WE_n_A14}), 32'(v.eRcw));
      checkOutput($sformatf("v%0d_a17", i), 32'(A17), 32'(v.eA17));
      checkOutput($sformatf("v%0d_a10", i), 32'(A10_AP), 32'(v.eA10));
      checkOutput($sformatf("v%0d_a9_a0", i), 32'(A9_A0), 32'(v.eA9));
      checkOutput($sformatf("v%0d_bg", i), 32'(bg_addr), 32'(v.eBg));
      checkOutput($sformatf("v%0d_ba", i), 32'(ba_addr), 32'(v.eBa));
      checkOutput($sformatf("v%0d_err", i), 32'(cmd_err), 32'(v.eErr));
      checkOutput($sformatf("v%0d_q", i), 32'(q_count), 32'(v.eQ));
   endtask

   vec_t vecs[17];
   vec_t idle;
   vec_t v;
   logic [9:0] model[$];
   logic [9:0] expCol;
   logic       accept;

   initial begin
      idle = '{1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 18'h0, 10'h0, S_NONE, 22'h0,
               DES, 2'b11, 1'b1, 3'b111, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'd3, 1'b0, 4'd0};

      //            push  op     rk    bg    ba    row       col      stb            mrs                         cmd   cs     actN  rcw     a17   a10   a9       bg    ba    err   q
      vecs[0]  = '{1'b1, RD_R,  1'b0, 2'd1, 2'd2, 18'h2ABCD, 10'h155, S_NONE,        22'h0,                      DES,  2'b11, 1'b1, 3'b111, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'd3, 1'b0, 4'd1};
      vecs[1]  = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_ACT,         22'h0,                      ACT,  2'b10, 1'b0, 3'b010, 1'b1, 1'b0, 10'h3CD, 2'd1, 2'd2, 1'b0, 4'd1};
      vecs[2]  = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_CAS,         22'h0,                      RD,   2'b10, 1'b1, 3'b101, 1'b1, 1'b0, 10'h155, 2'd1, 2'd2, 1'b0, 4'd0};
      vecs[3]  = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_CAS,         22'h0,                      DES,  2'b11, 1'b1, 3'b111, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'd3, 1'b1, 4'd0};
      vecs[4]  = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_NONE,        22'h0,                      DES,  2'b11, 1'b1, 3'b111, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'd3, 1'b0, 4'd0};
      vecs[5]  = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_PRE,         22'h0,                      DES,  2'b11, 1'b1, 3'b111, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'd3, 1'b1, 4'd0};
      vecs[6]  = '{1'b1, WR_R,  1'b1, 2'd2, 2'd1, 18'h0,     10'h0AA, S_NONE,        22'h0,                      DES,  2'b11, 1'b1, 3'b111, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'd3, 1'b0, 4'd1};
      vecs[7]  = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_PRE,         22'h0,                      PRE,  2'b01, 1'b1, 3'b010, 1'b1, 1'b0, 10'h3FF, 2'd2, 2'd1, 1'b0, 4'd1};
      vecs[8]  = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_REF | S_CAS, 22'h0,                      REF,  2'b00, 1'b1, 3'b001, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'd3, 1'b1, 4'd1};
      vecs[9]  = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_CAS,         22'h0,                      WR,   2'b01, 1'b1, 3'b100, 1'b1, 1'b0, 10'h0AA, 2'd2, 2'd1, 1'b0, 4'd0};
      vecs[10] = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_PREA,        22'h0,                      PREA, 2'b00, 1'b1, 3'b010, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'd3, 1'b0, 4'd0};
      vecs[11] = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_ZQ,          22'h0,                      ZQCL, 2'b00, 1'b1, 3'b110, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'd3, 1'b0, 4'd0};
      vecs[12] = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_MRS,         {2'b01, 2'b10, 18'h20C35},  MRS,  2'b00, 1'b1, 3'b000, 1'b1, 1'b1, 10'h035, 2'd1, 2'd2, 1'b0, 4'd0};
      vecs[13] = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_DES | S_ACT, 22'h0,                      DES,  2'b11, 1'b1, 3'b111, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'd3, 1'b1, 4'd0};
      vecs[14] = '{1'b1, RDA_R, 1'b0, 2'd0, 2'd3, 18'h1C000, 10'h201, S_ACT,         22'h0,                      DES,  2'b11, 1'b1, 3'b111, 1'b1, 1'b1, 10'h3FF, 2'd3, 2'd3, 1'b1, 4'd1};
      vecs[15] = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_ACT,         22'h0,                      ACT,  2'b10, 1'b0, 3'b111, 1'b0, 1'b0, 10'h000, 2'd0, 2'd3, 1'b0, 4'd1};
      vecs[16] = '{1'b0, RD_R,  1'b0, 2'd0, 2'd0, 18'h0,     10'h0,   S_CAS,         22'h0,                      RDA,  2'b10, 1'b1, 3'b101, 1'b1, 1'b1, 10'h201, 2'd0, 2'd3, 1'b0, 4'd0};

      // Reset for two cycles, release at a falling edge
      reset = 1'b1;
      req_valid = 1'b0; req_op = 2'd0; req_rank = 1'b0; req_bg = 2'd0; req_ba = 2'd0;
      req_row = 18'h0; req_col = 10'h0; mrs_data = 22'h0;
      {des_rdy, ref_rdy, prea_rdy, pre_rdy, mrs_rdy, zqcl_rdy, act_rdy, cas_rdy} = S_NONE;
      @(posedge CK_t);
      @(posedge CK_t);
      @(negedge CK_t);
      reset = 1'b0;
      checkOutput("rst_cs_n", 32'(cs_n), 32'h3);
      checkOutput("rst_a9_a0", 32'(A9_A0), 32'h3FF);
      checkOutput("rst_cmd", 32'(cmd_issued), 32'(DES));
      checkOutput("rst_ready", 32'(req_ready), 32'h1);
      checkOutput("rst_q", 32'(q_count), 32'h0);
      checkOutput("rst_err", 32'(cmd_err), 32'h0);

      // Table-driven single-cycle vectors
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i]);
         checkVector(i, vecs[i]);
      end

      // Fill the FIFO to DEPTH with distinct columns
      for (int i = 0; i < 8; i++) begin
         v = idle;
         v.push = 1'b1;
         v.col  = 10'h100 + 10'(i);
         applyStimulus(v);
         model.push_back(v.col);
      end
      checkOutput("fill_q", 32'(q_count), 32'd8);
      checkOutput("fill_ready", 32'(req_ready), 32'h0);

      // A push while full is dropped
      v = idle;
      v.push = 1'b1;
      v.col  = 10'h1FF;
      applyStimulus(v);
      checkOutput("overflow_q", 32'(q_count), 32'd8);

      // Push with cas_rdy every cycle: order must follow the model queue
      for (int k = 0; k < 20; k++) begin
         v = idle;
         v.push = 1'b1;
         v.col  = 10'h200 + 10'(k);
         v.stb  = S_CAS;
         accept = (model.size() < 8);
         expCol = model.pop_front();
         if (accept) model.push_back(v.col);
         applyStimulus(v);
         checkOutput($sformatf("wrap%0d_cmd", k), 32'(cmd_issued), 32'(RD));
         checkOutput($sformatf("wrap%0d_col", k), 32'(A9_A0), 32'(expCol));
         checkOutput($sformatf("wrap%0d_q", k), 32'(q_count), 32'(model.size()));
      end

      // Drain remaining entries in order
      for (int k = 0; k < 8 && model.size() > 0; k++) begin
         v = idle;
         v.stb = S_CAS;
         expCol = model.pop_front();
         applyStimulus(v);
         checkOutput($sformatf("drain%0d_col", k), 32'(A9_A0), 32'(expCol));
         checkOutput($sformatf("drain%0d_q", k), 32'(q_count), 32'(model.size()));
      end
      v = idle;
      v.stb = S_CAS;
      applyStimulus(v);
      checkOutput("drained_err", 32'(cmd_err), 32'h1);
      checkOutput("drained_cmd", 32'(cmd_issued), 32'(DES));

      // WRA on rank 1 with a second entry queued, then reset mid-operation
      v = idle;
      v.push = 1'b1; v.op = WRA_R; v.rank = 1'b1; v.col = 10'h3C3;
      applyStimulus(v);
      v = idle;
      v.push = 1'b1; v.op = RD_R; v.rank = 1'b0; v.col = 10'h011;
      applyStimulus(v);
      v = idle;
      v.stb = S_CAS;
      applyStimulus(v);
      checkOutput("wra_cmd", 32'(cmd_issued), 32'(WRA));
      checkOutput("wra_cs_n", 32'(cs_n), 32'h1);
      checkOutput("wra_a10", 32'(A10_AP), 32'h1);
      checkOutput("wra_we", 32'(WE_n_A14), 32'h0);
      checkOutput("wra_col", 32'(A9_A0), 32'h3C3);
      checkOutput("wra_q", 32'(q_count), 32'h1);

      reset = 1'b1;
      applyStimulus(idle);
      reset = 1'b0;
      checkOutput("mid_rst_q", 32'(q_count), 32'h0);
      checkOutput("mid_rst_cs_n", 32'(cs_n), 32'h3);
      checkOutput("mid_rst_cmd", 32'(cmd_issued), 32'(DES));
      checkOutput("mid_rst_a9_a0", 32'(A9_A0), 32'h3FF);
      checkOutput("mid_rst_ready", 32'(req_ready), 32'h1);

      // Queue was discarded: a CAS now underflows
      v = idle;
      v.stb = S_CAS;
      applyStimulus(v);
      checkOutput("post_rst_err", 32'(cmd_err), 32'h1);
      checkOutput("post_rst_cmd", 32'(cmd_issued), 32'(DES));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
